// File: rtl/spr_pkg.sv
// spr_pkg: shared definitions for the multi-channel SPR red core.
//   DEF_DW / DEF_OW / DEF_GW / DEF_FRAC : default sample, output and gain widths
//   gain_idx()                          : is_edge one-hot -> 2-bit gain index
package spr_pkg;

  localparam int DEF_DW   = 12;
  localparam int DEF_OW   = 11;
  localparam int DEF_GW   = 14;
  localparam int DEF_FRAC = 8;

  // Edge flag [3] selects gain 0 ... flag [0] selects gain 3. Anything that
  // is not exactly one-hot falls back to gain 0.
  function automatic logic [1:0] gain_idx(input logic [3:0] is_edge);
    case (is_edge)
      4'b1000: gain_idx = 2'd0;
      4'b0100: gain_idx = 2'd1;
      4'b0010: gain_idx = 2'd2;
      4'b0001: gain_idx = 2'd3;
      default: gain_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spr_lane.sv
// spr_lane: two-stage datapath for one colour lane.
//   Stage 1 registers sum = prev + curr (DW+1 bits) and the selected gain.
//   Stage 2 produces either the quarter-average or sum*gain >> FRAC,
//   saturated to OW bits, plus a flag marking a saturated special output.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous pipeline clear (wins over en)
//   en              pipeline advance
//   prev, curr      input samples
//   gain, gain_sel  this lane's four gains and the stage-1 selection
//   special         stage-1 special flag (registered by the parent)
//   out, sat        stage-2 result and saturation flag
// Build option: SPR_ROUND_EN enables round-half-up on both paths.
module spr_lane
  import spr_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW,
  parameter int GW   = DEF_GW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   prev,
  input  logic [DW-1:0]   curr,
  input  logic [4*GW-1:0] gain,
  input  logic [1:0]      gain_sel,
  input  logic            special,
  output logic [OW-1:0]   out,
  output logic            sat
);

  localparam int SW = DW + 1;   // lossless sum width
  localparam int PW = SW + GW;  // full product width
  localparam int QW = PW + 1;   // product plus headroom for the rounding add

  logic [SW-1:0] sum_q;
  logic [GW-1:0] gain_q;
  logic [PW-1:0] prod;
  logic [QW-1:0] q;
  logic          ovf;
  logic [OW-1:0] sp_out;
  logic [OW-1:0] avg_out;
`ifdef SPR_ROUND_EN
  localparam int AW = SW + 1;
  localparam logic [QW-1:0] HALF = QW'(1) << (FRAC - 1);
  logic [AW-1:0] avg;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      gain_q <= '0;
    end else if (clr) begin
      sum_q  <= '0;
      gain_q <= '0;
    end else if (en) begin
      sum_q  <= SW'(prev) + SW'(curr);
      gain_q <= gain[int'(gain_sel)*GW +: GW];
    end
  end

  // NOTE: every variable in this block is assigned on every path, so no
  // latch can be inferred.
  always_comb begin
    prod = PW'(sum_q) * PW'(gain_q);
`ifdef SPR_ROUND_EN
    q       = ({1'b0, prod} + HALF) >> FRAC;
    avg     = ({1'b0, sum_q} + AW'(2)) >> 2;
    avg_out = ((avg >> OW) != '0) ? '1 : avg[OW-1:0];
`else
    q       = {1'b0, prod} >> FRAC;
    avg_out = OW'(sum_q >> 2);
`endif
    // Any set bit at or above OW overflows, not just bit OW itself.
    ovf    = (q >> OW) != '0;
    sp_out = ovf ? '1 : q[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      out <= '0;
      sat <= 1'b0;
    end else if (en) begin
      out <= special ? sp_out : avg_out;
      sat <= special & ovf;
    end
  end

endmodule

// File: rtl/spr_core_mc.sv
// spr_core_mc: multi-channel SPR red core, NCH lanes in parallel.
//   Derives the special flag and gain index, runs the valid pipeline,
//   instantiates one spr_lane per channel and counts saturated lane outputs
//   per frame.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_hs, i_vs            line/frame sync, low clears the pipeline; i_vs 1->0
//                         closes the frame statistics
//   en                    pipeline advance (0 holds everything)
//   i_valid               input pixel valid
//   spr_seperate_case     1: special from is_edge, 0: from is_original
//   is_original, is_edge  special / edge direction flags
//   gain                  NCH x 4 gains, lane c index k at [(c*4+k)*GW +: GW]
//   prev, curr            NCH input samples, lane c at [c*DW +: DW]
//   o_valid, core_out     2-cycle-latency result, lane c at [c*OW +: OW]
//   o_sat_frame           saturated lane outputs in the last completed frame
// Build option: SPR_ROUND_EN (handled inside spr_lane).
module spr_core_mc
  import spr_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW,
  parameter int GW   = DEF_GW,
  parameter int FRAC = DEF_FRAC,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                en,
  input  logic                i_valid,
  input  logic                spr_seperate_case,
  input  logic                is_original,
  input  logic [3:0]          is_edge,
  input  logic [NCH*4*GW-1:0] gain,
  input  logic [NCH*DW-1:0]   prev,
  input  logic [NCH*DW-1:0]   curr,
  output logic                o_valid,
  output logic [NCH*OW-1:0]   core_out,
  output logic [CW-1:0]       o_sat_frame
);

  localparam int PCW = $clog2(NCH + 1);

  logic           clr;
  logic           special;
  logic [1:0]     gain_sel;
  logic           v1;
  logic           sp1;
  logic [NCH-1:0] sat;
  logic [PCW-1:0] pop;
  logic [CW:0]    total;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           vs_q;
  logic           frame_close;

  assign clr         = !i_hs || !i_vs;
  assign special     = spr_seperate_case ? |is_edge : is_original;
  assign gain_sel    = spr_seperate_case ? gain_idx(is_edge) : 2'd0;
  assign frame_close = vs_q && !i_vs;

  // Valid and special flag travel alongside the lane data; clear beats en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sp1     <= 1'b0;
      o_valid <= 1'b0;
    end else if (clr) begin
      v1      <= 1'b0;
      sp1     <= 1'b0;
      o_valid <= 1'b0;
    end else if (en) begin
      v1      <= i_valid;
      sp1     <= special;
      o_valid <= v1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    spr_lane #(
      .DW  (DW),
      .OW  (OW),
      .GW  (GW),
      .FRAC(FRAC)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (en),
      .prev    (prev[c*DW +: DW]),
      .curr    (curr[c*DW +: DW]),
      .gain    (gain[c*4*GW +: 4*GW]),
      .gain_sel(gain_sel),
      .special (sp1),
      .out     (core_out[c*OW +: OW]),
      .sat     (sat[c])
    );
  end

  // Each registered stage-2 output is counted once, on the enabled edge that
  // retires it. The counter is deliberately untouched by the sync clear.
  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++) pop = pop + PCW'(sat[c]);
    total    = {1'b0, cnt} + ((en && o_valid) ? (CW+1)'(pop) : '0);
    cnt_next = total[CW] ? '1 : total[CW-1:0];
  end

  // The closing edge's own increment belongs to the frame being closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      cnt         <= '0;
      o_sat_frame <= '0;
    end else begin
      vs_q <= i_vs;
      if (frame_close) begin
        o_sat_frame <= cnt_next;
        cnt         <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: doc/spr_core_mc.md
Name: spr_core_mc

Overview:
- Multi-channel, parametrised successor of the single-channel SPR red core.
- Per lane: sums prev and curr subpixel samples.
  - Non-special pixels: outputs the quarter-average (prev+curr)>>2.
  - Special pixels (edge / original-mode): outputs sum × selected edge gain >> FRAC, saturated to OW bits.
- Adds a valid pipeline, per-channel gains, full-range saturation and a per-frame saturation counter.
- Sits between the SPR edge detector and the output formatter.

Parameters:
- NCH, 3, number of colour lanes processed in parallel.
- DW, 12, input sample width.
- OW, 11, output sample width (must be ≤ DW+1).
- GW, 14, edge-gain width, unsigned fixed point.
- FRAC, 8, fractional bits of the gain.
- CW, 16, saturation-counter width.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- i_hs  in  1  line sync; low forces synchronous pipeline clear.
- i_vs  in  1  frame sync; low forces synchronous pipeline clear; its 1→0 edge closes frame statistics.
- en  in  1  pipeline advance; 0 holds all stage registers.
- i_valid  in  1  input pixel valid.
- spr_seperate_case  in  1  1: edge-driven special case; 0: is_original-driven.
- is_original  in  1  special flag used when spr_seperate_case=0.
- is_edge  in  4  edge direction flags, one-hot expected, [3]→gain0 … [0]→gain3.
- gain  in  NCH*4*GW  per-lane gains; lane c, index k at [(c*4+k)*GW +: GW].
- prev  in  NCH*DW  previous subpixels, lane c at [c*DW +: DW].
- curr  in  NCH*DW  current subpixels.
- o_valid  out  1  output valid.
- core_out  out  NCH*OW  results, lane c at [c*OW +: OW].
- o_sat_frame  out  CW  saturated lane-outputs counted in the last completed frame.

Behaviour:
- Reset (rst_n=0, async): all stage registers, o_valid, core_out, internal counter and o_sat_frame = 0.
- Sync clear (!i_hs || !i_vs at posedge): stage registers, o_valid and core_out = 0. Overrides en. The saturation counter is unaffected.

Special flag:
- spr_seperate_case=1: special = |is_edge.
- spr_seperate_case=0: special = is_original.

Gain index:
- spr_seperate_case=0: index 0.
- Otherwise the one-hot position in is_edge.
- Zero or multi-hot is_edge → index 0.

Stage 1 (when en):
- sum_c = prev_c + curr_c, DW+1 bits, no loss.
- Registers gain_c, special and i_valid.

Stage 2 (when en), per lane:
- If special: p = sum_c × gain_c, DW+1+GW bits; q = p >> FRAC; out = (q ≥ 2^OW) ? all-ones : q[OW-1:0].
  - All upper bits are checked for saturation, not only bit OW.
- Else: out = sum_c >> 2, truncated to OW.
- Registers out, o_valid = stage-1 valid, and sat_c = special & overflow.

Timing and stall:
- Latency: 2 enabled cycles from input to core_out/o_valid.
- en=0: everything holds, including o_valid, and the counter does not increment.

Saturation counter:
- Each enabled cycle with stage-2 valid adds popcount(sat_c).
- Saturates at 2^CW−1; no wrap.

Frame close (i_vs 1→0, detected with a registered i_vs):
- o_sat_frame ← counter including the current cycle's increment; counter ← 0.
- Same cycle as a saturating increment: that increment goes into o_sat_frame, not the new frame.
- o_sat_frame holds between frame closes.

Optional Feature:
- SPR_ROUND_EN defined: special path uses q = (p + 2^(FRAC−1)) >> FRAC (round half up) before saturation; the average path uses (sum+2)>>2 with saturation to OW.
- Undefined: truncation only, as described above.

Decomposition:
- spr_pkg: gain-index encode function (is_edge → 2-bit index) and the shared localparam defaults DW/OW/GW/FRAC.
- One sub-module, spr_lane: the per-channel datapath (both stages for one lane, output plus sat flag).
- spr_core_mc instantiates NCH lanes via generate and owns the valid pipeline, special-flag logic and saturation counter.

Test Plan:
- Average path: NCH=3, special=0, prev=curr=0x800 every lane → after 2 cycles core_out lanes = 0x400, o_valid=1.
- Edge gain select: seperate=1, is_edge=0100, lane1 gain1=0x0200 (2.0), prev=0x100, curr=0x100 → lane1 out=0x400; is_edge=0110 → gain0 used.
- Saturation: special, gain=0x3FFF, prev=curr=0xFFF → out=0x7FF, counter +1 per lane. Also sum=0x200, gain=0x1000 (q=0x2000, bit OW clear but higher bit set) → 0x7FF.
- Stall/clear: en=0 for 3 cycles mid-stream → outputs frozen. i_hs=0 one cycle → o_valid=0, core_out=0, counter intact.
- Frame stats: 5 saturating lane-outputs, then i_vs 1→0 → o_sat_frame=5, next frame starts at 0. Saturating output on the closing cycle → counted in o_sat_frame.
- Async reset mid-pipeline: rst_n low between clock edges → all outputs 0 immediately. SPR_ROUND_EN build: sum=0x3, special=0 → out=0x1.
